// File: rtl/atb_pad_sequencer.sv
// Analog test bus pad sequencer: one-hot switch enables with break-before-make and settle timing.
// Optional pad-net discharge during dead time when ATB_PAD_DISCHARGE_EN is defined.
module atb_pad_sequencer #(
    parameter int unsigned N_CH       = 8,
    parameter int unsigned CW         = 3,
    parameter int unsigned BBM_CYC    = 4,
    parameter int unsigned SETTLE_CYC = 16
) (
    input  logic            clk,
    input  logic            reset,
    input  logic            req_valid,
    input  logic [CW:0]     req_ch,
    output logic            req_ready,
    output logic [N_CH-1:0] sw_en,
    output logic            gnd_en,
    output logic [CW:0]     cur_ch,
    output logic            busy,
    output logic            settled
);

    localparam int unsigned CNT_MAX = (BBM_CYC > SETTLE_CYC) ? BBM_CYC : SETTLE_CYC;
    localparam int unsigned CNT_W   = $clog2(CNT_MAX + 1);

    localparam logic [CW:0]      CH_NONE     = (CW+1)'(N_CH);
    localparam logic [CNT_W-1:0] BBM_LOAD    = CNT_W'(BBM_CYC - 1);
    localparam logic [CNT_W-1:0] SETTLE_LOAD = CNT_W'(SETTLE_CYC - 1);

    typedef enum logic [1:0] {StIdle, StBreak, StSettle, StActive} state_t;

    state_t            state_q, state_d;
    logic [CNT_W-1:0]  cnt_q, cnt_d;
    logic [N_CH-1:0]   sw_en_q, sw_en_d;
    logic [CW:0]       cur_ch_q, cur_ch_d;
    logic              settled_q, settled_d;
    logic              gnd_en_q, gnd_en_d;

    always_ff @(posedge clk) begin
        if (reset) begin
            state_q   <= StIdle;
            cnt_q     <= '0;
            sw_en_q   <= '0;
            cur_ch_q  <= CH_NONE;
            settled_q <= 1'b0;
            gnd_en_q  <= 1'b0;
        end else begin
            state_q   <= state_d;
            cnt_q     <= cnt_d;
            sw_en_q   <= sw_en_d;
            cur_ch_q  <= cur_ch_d;
            settled_q <= settled_d;
            gnd_en_q  <= gnd_en_d;
        end
    end

    always_comb begin
        state_d   = state_q;
        cnt_d     = cnt_q;
        sw_en_d   = sw_en_q;
        cur_ch_d  = cur_ch_q;
        settled_d = settled_q;

        unique case (state_q)
            StIdle, StActive: begin
                if (req_valid) begin
                    if (req_ch >= CH_NONE) begin
                        // Disconnect still takes the full dead time so the pad net sees a clean break.
                        sw_en_d   = '0;
                        cur_ch_d  = CH_NONE;
                        settled_d = 1'b0;
                        cnt_d     = BBM_LOAD;
                        state_d   = StBreak;
                    end else if (state_q == StIdle || req_ch != cur_ch_q) begin
                        sw_en_d   = '0;
                        cur_ch_d  = req_ch;
                        settled_d = 1'b0;
                        cnt_d     = BBM_LOAD;
                        state_d   = StBreak;
                    end
                end
            end
            StBreak: begin
                if (cnt_q == '0) begin
                    if (cur_ch_q == CH_NONE) begin
                        state_d = StIdle;
                    end else begin
                        for (int i = 0; i < int'(N_CH); i++) begin
                            sw_en_d[i] = (cur_ch_q == (CW+1)'(i));
                        end
                        cnt_d   = SETTLE_LOAD;
                        state_d = StSettle;
                    end
                end else begin
                    cnt_d = cnt_q - CNT_W'(1);
                end
            end
            StSettle: begin
                if (cnt_q == '0) begin
                    settled_d = 1'b1;
                    state_d   = StActive;
                end else begin
                    cnt_d = cnt_q - CNT_W'(1);
                end
            end
            default: begin
                sw_en_d = '0;
                state_d = StIdle;
            end
        endcase

`ifdef ATB_PAD_DISCHARGE_EN
        gnd_en_d = (state_d == StBreak);
`else
        gnd_en_d = 1'b0;
`endif
    end

    assign busy      = (state_q == StBreak) || (state_q == StSettle);
    assign req_ready = !busy;
    assign sw_en     = sw_en_q;
    assign gnd_en    = gnd_en_q;
    assign cur_ch    = cur_ch_q;
    assign settled   = settled_q;

endmodule

// File: tb/tb_atb_pad_sequencer.sv
// Self-checking bench for atb_pad_sequencer: vector table, corner sequences, and randomized
// traffic checked against a timeline model (elapsed cycles since the last accepted request).
module tb_atb_pad_sequencer;

    localparam int unsigned N_CH       = 8;
    localparam int unsigned CW         = 3;
    localparam int unsigned BBM_CYC    = 4;
    localparam int unsigned SETTLE_CYC = 16;

    logic            clk = 1'b0;
    logic            reset;
    logic            req_valid;
    logic [CW:0]     req_ch;
    logic            req_ready;
    logic [N_CH-1:0] sw_en;
    logic            gnd_en;
    logic [CW:0]     cur_ch;
    logic            busy;
    logic            settled;

    atb_pad_sequencer #(
        .N_CH      (N_CH),
        .CW        (CW),
        .BBM_CYC   (BBM_CYC),
        .SETTLE_CYC(SETTLE_CYC)
    ) dut (
        .clk      (clk),
        .reset    (reset),
        .req_valid(req_valid),
        .req_ch   (req_ch),
        .req_ready(req_ready),
        .sw_en    (sw_en),
        .gnd_en   (gnd_en),
        .cur_ch   (cur_ch),
        .busy     (busy),
        .settled  (settled)
    );

    always #5 clk = ~clk;

    int n_cmp = 0;
    int n_err = 0;

    // Timeline model: target channel and the edge at which it was accepted.
    int cyc    = 0;
    bit m_have = 1'b0;
    int m_tgt  = N_CH;
    int m_k    = 0;

    logic [N_CH-1:0] e_sw;
    logic            e_gnd;
    logic [CW:0]     e_cur;
    logic            e_busy, e_set, e_rdy;

    logic [N_CH-1:0] last_nz  = '0;
    int              zero_run = 0;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s at cycle %0d: got %0h, expected %0h", name, cyc, act, exp);
        end
    endtask

    function automatic void calc_exp();
        int e;
        e_sw   = '0;
        e_gnd  = 1'b0;
        e_cur  = (CW+1)'(N_CH);
        e_busy = 1'b0;
        e_set  = 1'b0;
        if (m_have) begin
            e     = cyc - m_k;
            e_cur = (CW+1)'(m_tgt);
            if (e < int'(BBM_CYC)) begin
                e_busy = 1'b1;
`ifdef ATB_PAD_DISCHARGE_EN
                e_gnd = 1'b1;
`endif
            end else if (m_tgt < int'(N_CH)) begin
                e_sw = N_CH'(1) << m_tgt;
                if (e < int'(BBM_CYC + SETTLE_CYC)) e_busy = 1'b1;
                else e_set = 1'b1;
            end
        end
        e_rdy = !e_busy;
    endfunction

    task automatic step();
        calc_exp();
        @(posedge clk);
        cyc++;
        if (reset) begin
            m_have = 1'b0;
        end else if (req_valid && e_rdy) begin
            if (!(e_set && int'(req_ch) == m_tgt)) begin
                m_have = 1'b1;
                m_k    = cyc;
                m_tgt  = (int'(req_ch) >= int'(N_CH)) ? int'(N_CH) : int'(req_ch);
            end
        end
        #1;
        calc_exp();
        chk("sw_en", 32'(sw_en), 32'(e_sw));
        chk("gnd_en", 32'(gnd_en), 32'(e_gnd));
        chk("cur_ch", 32'(cur_ch), 32'(e_cur));
        chk("busy", 32'(busy), 32'(e_busy));
        chk("settled", 32'(settled), 32'(e_set));
        chk("req_ready", 32'(req_ready), 32'(e_rdy));
        chk("popcount_le1", 32'($countones(sw_en) <= 1), 32'd1);
        chk("gnd_while_sw", 32'(gnd_en && (sw_en != '0)), 32'd0);
        if (sw_en == '0) begin
            zero_run++;
        end else begin
            if (last_nz != '0 && sw_en != last_nz)
                chk("bbm_gap", 32'(zero_run >= int'(BBM_CYC)), 32'd1);
            last_nz  = sw_en;
            zero_run = 0;
        end
    endtask

    task automatic drive(input logic r, input logic v, input logic [CW:0] ch);
        reset     = r;
        req_valid = v;
        req_ch    = ch;
    endtask

    typedef struct packed {
        logic            rst;
        logic            vld;
        logic [CW:0]     ch;
        int              n;
        logic [N_CH-1:0] sw;
        logic [CW:0]     cur;
        logic            bsy;
        logic            set;
    } vec_t;

    vec_t vecs[14];

    initial begin
        int zeros;
        int gnds;
        bit seen;

        drive(1'b1, 1'b0, '0);

        // Reset, ch3, ch3->ch5, same-channel no-op, disconnect.
        vecs[0]  = '{1'b1, 1'b0, 4'd0, 1,  8'h00, 4'd8, 1'b0, 1'b0};
        vecs[1]  = '{1'b0, 1'b1, 4'd3, 1,  8'h00, 4'd3, 1'b1, 1'b0};
        vecs[2]  = '{1'b0, 1'b0, 4'd0, 3,  8'h00, 4'd3, 1'b1, 1'b0};
        vecs[3]  = '{1'b0, 1'b0, 4'd0, 1,  8'h08, 4'd3, 1'b1, 1'b0};
        vecs[4]  = '{1'b0, 1'b0, 4'd0, 15, 8'h08, 4'd3, 1'b1, 1'b0};
        vecs[5]  = '{1'b0, 1'b0, 4'd0, 1,  8'h08, 4'd3, 1'b0, 1'b1};
        vecs[6]  = '{1'b0, 1'b1, 4'd5, 1,  8'h00, 4'd5, 1'b1, 1'b0};
        vecs[7]  = '{1'b0, 1'b0, 4'd0, 3,  8'h00, 4'd5, 1'b1, 1'b0};
        vecs[8]  = '{1'b0, 1'b0, 4'd0, 1,  8'h20, 4'd5, 1'b1, 1'b0};
        vecs[9]  = '{1'b0, 1'b0, 4'd0, 16, 8'h20, 4'd5, 1'b0, 1'b1};
        vecs[10] = '{1'b0, 1'b1, 4'd5, 1,  8'h20, 4'd5, 1'b0, 1'b1};
        vecs[11] = '{1'b0, 1'b1, 4'd8, 1,  8'h00, 4'd8, 1'b1, 1'b0};
        vecs[12] = '{1'b0, 1'b0, 4'd0, 3,  8'h00, 4'd8, 1'b1, 1'b0};
        vecs[13] = '{1'b0, 1'b0, 4'd0, 1,  8'h00, 4'd8, 1'b0, 1'b0};

        for (int i = 0; i < 14; i++) begin
            drive(vecs[i].rst, vecs[i].vld, vecs[i].ch);
            step();
            drive(1'b0, 1'b0, '0);
            for (int j = 1; j < vecs[i].n; j++) step();
            chk($sformatf("vec%0d_sw_en", i), 32'(sw_en), 32'(vecs[i].sw));
            chk($sformatf("vec%0d_cur_ch", i), 32'(cur_ch), 32'(vecs[i].cur));
            chk($sformatf("vec%0d_busy", i), 32'(busy), 32'(vecs[i].bsy));
            chk($sformatf("vec%0d_settled", i), 32'(settled), 32'(vecs[i].set));
            chk($sformatf("vec%0d_req_ready", i), 32'(req_ready), 32'(!vecs[i].bsy));
        end

        // Dead time length and discharge window on an ACTIVE ch2 -> ch6 switch.
        drive(1'b0, 1'b1, 4'd2);
        step();
        drive(1'b0, 1'b0, '0);
        repeat (BBM_CYC + SETTLE_CYC) step();
        chk("pre_switch_settled", 32'(settled), 32'd1);
        drive(1'b0, 1'b1, 4'd6);
        zeros = 0;
        gnds  = 0;
        seen  = 1'b0;
        for (int i = 0; i < 12; i++) begin
            step();
            drive(1'b0, 1'b0, '0);
            if (!seen && sw_en == '0) zeros++;
            if (sw_en != '0) seen = 1'b1;
            if (gnd_en) gnds++;
        end
        chk("switch_zero_cycles", 32'(zeros), 32'(BBM_CYC));
        chk("switch_target", 32'(sw_en), 32'h40);
`ifdef ATB_PAD_DISCHARGE_EN
        chk("gnd_cycles", 32'(gnds), 32'(BBM_CYC));
`else
        chk("gnd_cycles", 32'(gnds), 32'd0);
`endif
        repeat (SETTLE_CYC) step();

        // A request during SETTLE is dropped; the in-flight target wins.
        drive(1'b0, 1'b1, 4'd3);
        step();
        drive(1'b0, 1'b0, '0);
        repeat (BBM_CYC + 2) step();
        drive(1'b0, 1'b1, 4'd1);
        step();
        drive(1'b0, 1'b0, '0);
        repeat (SETTLE_CYC) step();
        chk("ignored_sw_en", 32'(sw_en), 32'h08);
        chk("ignored_cur_ch", 32'(cur_ch), 32'd3);
        chk("ignored_settled", 32'(settled), 32'd1);

        // Reset two cycles into SETTLE.
        drive(1'b0, 1'b1, 4'd4);
        step();
        drive(1'b0, 1'b0, '0);
        repeat (BBM_CYC + 2) step();
        drive(1'b1, 1'b0, '0);
        step();
        drive(1'b0, 1'b0, '0);
        chk("rst_mid_sw_en", 32'(sw_en), 32'd0);
        chk("rst_mid_busy", 32'(busy), 32'd0);
        chk("rst_mid_cur_ch", 32'(cur_ch), 32'd8);
        chk("rst_mid_req_ready", 32'(req_ready), 32'd1);

        // Randomized traffic including disconnect codes and occasional reset.
        for (int i = 0; i < 1500; i++) begin
            drive(1'($urandom_range(0, 149) == 0), 1'($urandom_range(0, 7) == 0),
                  (CW+1)'($urandom_range(0, 11)));
            step();
        end

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule

// File: doc/atb_pad_sequencer.md
# atb_pad_sequencer

Core-side controller for the analog test bus (ATB) that reaches the chip through the analog pass-through I/O cells. It drives the one-hot switch enables that connect one of N internal analog nodes to the shared pad net. It enforces break-before-make dead time and a settle interval, and reports when the selected node is valid at the pad. Sits between the digital test/config register block (request side) and the analog switch array feeding the analog I/O pad (switch side).

## Interface
Parameters:
- N_CH, 8, number of selectable analog channels (2..16)
- CW, 3, channel index width; must equal $clog2(N_CH)
- BBM_CYC, 4, break-before-make dead time in clocks (>=1)
- SETTLE_CYC, 16, settle time after make, in clocks (>=1)

Ports:
- clk  input  1  single clock, rising edge
- reset  input  1  synchronous, active-high
- req_valid  input  1  new selection request
- req_ch  input  CW+1  requested channel; values >= N_CH mean disconnect-all
- req_ready  output  1  request can be accepted this cycle
- sw_en  output  N_CH  one-hot (or zero) switch enables to the analog switch array
- gnd_en  output  1  pad-net discharge switch (see Configuration)
- cur_ch  output  CW+1  last accepted channel (N_CH after reset)
- busy  output  1  sequencing in progress
- settled  output  1  sw_en selection has completed SETTLE_CYC

## Operation
- FSM states: IDLE, BREAK, SETTLE, ACTIVE.
- Accept = req_valid && req_ready. req_ready = 1 in IDLE and ACTIVE, 0 in BREAK and SETTLE.
- IDLE/ACTIVE accept, req_ch < N_CH, req_ch != cur_ch or state IDLE: sw_en <= 0, cur_ch <= req_ch, settled <= 0, counter <= BBM_CYC-1, state -> BREAK.
- ACTIVE accept with req_ch == cur_ch: no switching, state stays ACTIVE, settled stays 1.
- Accept with req_ch >= N_CH (disconnect): sw_en <= 0, cur_ch <= N_CH, settled <= 0, state -> BREAK; at BREAK end go to IDLE, not SETTLE.
- BREAK: counter decrements; at 0, sw_en <= onehot(cur_ch), counter <= SETTLE_CYC-1, state -> SETTLE.
- SETTLE: counter decrements; at 0, settled <= 1, state -> ACTIVE.
- busy = (state == BREAK || state == SETTLE).
- Invariant: popcount(sw_en) <= 1 on every cycle; no cycle ever shows two enables or a direct one-to-another transition without >= BBM_CYC all-zero cycles between them.
- req_valid while req_ready = 0: ignored, not queued; requester must hold or retry.

## Timing
- Reset value of all outputs: sw_en = 0, gnd_en = 0, cur_ch = N_CH, busy = 0, settled = 0, req_ready = 1; state IDLE.
- Accept at edge k: from k, sw_en = 0 and busy = 1.
- sw_en = onehot after edge k+BBM_CYC.
- settled = 1 and busy = 0 after edge k+BBM_CYC+SETTLE_CYC; req_ready = 1 from the same cycle.
- Disconnect: busy = 0, state IDLE after edge k+BBM_CYC; settled stays 0.
- Reset asserted mid-sequence: next edge forces all reset values; no enable survives reset by more than one edge.
- All outputs registered; no combinational path from req_* to sw_en.

## Configuration
- ATB_PAD_DISCHARGE_EN defined: gnd_en = 1 for every cycle in BREAK (dead time), discharging the pad net before make. gnd_en is never 1 while sw_en != 0.
- Not defined: gnd_en is constant 0; all other behaviour identical.

## Test plan
(N_CH=8, BBM_CYC=4, SETTLE_CYC=16)
- Reset, then req_ch=3 at edge 0 -> sw_en=0 edges 0..3, sw_en=8'h08 from edge 4, settled=1 and req_ready=1 from edge 20.
- From ACTIVE ch3, request ch5 -> sw_en=0 for exactly 4 cycles, then 8'h20; popcount never >1. With macro, gnd_en=1 exactly those 4 cycles.
- ACTIVE ch5, request ch5 -> no sw_en change, settled stays 1, busy stays 0.
- Request req_ch=8 from ACTIVE -> sw_en=0, cur_ch=8, IDLE after 4 cycles, settled=0.
- req_valid pulsed during SETTLE with ch1 -> ignored, final sw_en=previous target.
- Assert reset 2 cycles into SETTLE -> next edge sw_en=0, busy=0, cur_ch=8, req_ready=1.
